// File: rtl/wave_generator.sv
// Configurable saw/triangle/square waveform generator with clamped, overflow-free stepping.
// Generation runs only from the captured configuration, never from the raw config inputs.
module wave_generator #(
   parameter int N = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         ena,
   input  logic         load,
   input  logic [1:0]   mode,
   input  logic [N-1:0] step,
   input  logic [N-1:0] lo,
   input  logic [N-1:0] hi,
   output logic [N-1:0] out,
   output logic         dir_up,
   output logic         wrap,
   output logic         cfg_err
);

   typedef enum logic {
      DOWN = 1'b0,
      UP   = 1'b1
   } dir_t;

   localparam logic [1:0] SAW_UP   = 2'd0;
   localparam logic [1:0] SAW_DOWN = 2'd1;
   localparam logic [1:0] TRIANGLE = 2'd2;
   localparam logic [1:0] SQUARE   = 2'd3;

   logic [1:0]   mode_q, mode_d;
   logic [N-1:0] step_q, step_d;
   logic [N-1:0] lo_q, lo_d;
   logic [N-1:0] hi_q, hi_d;
   logic [N-1:0] phase_q, phase_d;
   logic [N-1:0] out_q, out_d;
   dir_t         dir_q, dir_d;
   logic         wrap_q, wrap_d;
   logic         err_q, err_d;

   logic [N-1:0] step_eff;
   logic [N:0]   sum_w;
   logic [N:0]   diff_w;
   logic [N-1:0] up_sat;
   logic [N-1:0] dn_sat;
   logic         bad_cfg;

   // Saturate a rising step at the upper bound; the extra bit catches carry-out.
   function automatic logic [N-1:0] sat_up(input logic [N:0] sum, input logic [N-1:0] bound);
      if (sum > {1'b0, bound})
         return bound;
      return sum[N-1:0];
   endfunction

   // Saturate a falling step at the lower bound; the extra bit flags a borrow.
   function automatic logic [N-1:0] sat_dn(input logic [N:0] diff, input logic [N-1:0] bound);
      if (diff[N] || (diff[N-1:0] < bound))
         return bound;
      return diff[N-1:0];
   endfunction

   assign step_eff = (step_q == '0) ? {{(N-1){1'b0}}, 1'b1} : step_q;
   assign sum_w    = {1'b0, phase_q} + {1'b0, step_eff};
   assign diff_w   = {1'b0, phase_q} - {1'b0, step_eff};
   assign up_sat   = sat_up(sum_w, hi_q);
   assign dn_sat   = sat_dn(diff_w, lo_q);
   assign bad_cfg  = (lo >= hi);

   always_comb begin
      mode_d  = mode_q;
      step_d  = step_q;
      lo_d    = lo_q;
      hi_d    = hi_q;
      phase_d = phase_q;
      out_d   = out_q;
      dir_d   = dir_q;
      wrap_d  = 1'b0;
      err_d   = err_q;

      if (load) begin
         mode_d = mode;
         step_d = step;
         lo_d   = lo;
         hi_d   = hi;
         err_d  = bad_cfg;
         if (!bad_cfg && mode == SAW_DOWN) begin
            phase_d = hi;
            dir_d   = DOWN;
         end else begin
            phase_d = lo;
            dir_d   = UP;
         end
         out_d = phase_d;
      end else if (err_q) begin
         phase_d = lo_q;
         out_d   = lo_q;
         dir_d   = UP;
      end else if (ena) begin
         case (mode_q)
            SAW_UP: begin
               dir_d = UP;
               if (phase_q == hi_q) begin
                  phase_d = lo_q;
                  wrap_d  = 1'b1;
               end else begin
                  phase_d = up_sat;
               end
            end
            SAW_DOWN: begin
               dir_d = DOWN;
               if (phase_q == lo_q) begin
                  phase_d = hi_q;
                  wrap_d  = 1'b1;
               end else begin
                  phase_d = dn_sat;
               end
            end
            default: begin
               if (dir_q == UP) begin
                  phase_d = up_sat;
                  if (up_sat == hi_q)
                     dir_d = DOWN;
               end else begin
                  phase_d = dn_sat;
                  if (dn_sat == lo_q) begin
                     dir_d  = UP;
                     wrap_d = 1'b1;
                  end
               end
            end
         endcase
         if (mode_q == SQUARE)
            out_d = (dir_d == UP) ? hi_q : lo_q;
         else
            out_d = phase_d;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         mode_q  <= TRIANGLE;
         step_q  <= {{(N-1){1'b0}}, 1'b1};
         lo_q    <= '0;
         hi_q    <= '1;
         phase_q <= '0;
         out_q   <= '0;
         dir_q   <= UP;
         wrap_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         mode_q  <= mode_d;
         step_q  <= step_d;
         lo_q    <= lo_d;
         hi_q    <= hi_d;
         phase_q <= phase_d;
         out_q   <= out_d;
         dir_q   <= dir_d;
         wrap_q  <= wrap_d;
         err_q   <= err_d;
      end
   end

   assign out     = out_q;
   assign dir_up  = (dir_q == UP);
   assign wrap    = wrap_q;
   assign cfg_err = err_q;

endmodule

// File: tb/tb_wave_generator.sv
// Directed bench for wave_generator (N=8) with hand-computed expected sequences.
module tb_wave_generator;

   localparam int N = 8;

   logic         clk = 1'b0;
   logic         rst;
   logic         ena;
   logic         load;
   logic [1:0]   mode;
   logic [N-1:0] step;
   logic [N-1:0] lo;
   logic [N-1:0] hi;
   logic [N-1:0] out;
   logic         dir_up;
   logic         wrap;
   logic         cfg_err;

   int checks = 0;
   int errors = 0;

   wave_generator #(.N(N)) dut (
      .clk     (clk),
      .rst     (rst),
      .ena     (ena),
      .load    (load),
      .mode    (mode),
      .step    (step),
      .lo      (lo),
      .hi      (hi),
      .out     (out),
      .dir_up  (dir_up),
      .wrap    (wrap),
      .cfg_err (cfg_err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // One enabled cycle, then compare out/wrap/dir_up.
   task automatic adv(input string tag, input int e_out, input int e_wrap, input int e_dir);
      tick();
      chk({tag, " out"}, 32'(out), 32'(e_out));
      chk({tag, " wrap"}, 32'(wrap), 32'(e_wrap));
      chk({tag, " dir_up"}, 32'(dir_up), 32'(e_dir));
   endtask

   // Single-cycle load; raw inputs are scrambled afterwards so only captured config matters.
   task automatic do_load(input logic [1:0] m, input int s, input int l, input int h, input logic en);
      mode = m;
      step = N'(s);
      lo   = N'(l);
      hi   = N'(h);
      load = 1'b1;
      ena  = en;
      tick();
      load = 1'b0;
      mode = 2'd3;
      step = 8'd77;
      lo   = 8'd0;
      hi   = 8'd255;
   endtask

   initial begin
      rst = 1'b1; ena = 1'b0; load = 1'b0;
      mode = 2'd0; step = '0; lo = '0; hi = '0;
      tick();
      tick();
      rst = 1'b0;
      chk("rst out", 32'(out), 0);
      chk("rst dir_up", 32'(dir_up), 1);
      chk("rst wrap", 32'(wrap), 0);
      chk("rst cfg_err", 32'(cfg_err), 0);

      // Default triangle full-range ramp.
      ena = 1'b1;
      for (int i = 1; i <= 255; i++)
         adv("tri_up", i, 0, (i == 255) ? 0 : 1);
      for (int i = 254; i >= 0; i--)
         adv("tri_dn", i, (i == 0) ? 1 : 0, (i == 0) ? 1 : 0);
      adv("tri_again", 1, 0, 1);

      // Saw-up 10..20 step 4.
      ena = 1'b0;
      do_load(2'd0, 4, 10, 20, 1'b0);
      chk("sawup load out", 32'(out), 10);
      chk("sawup load wrap", 32'(wrap), 0);
      chk("sawup load err", 32'(cfg_err), 0);
      ena = 1'b1;
      adv("sawup", 14, 0, 1);
      adv("sawup", 18, 0, 1);
      adv("sawup", 20, 0, 1);
      adv("sawup", 10, 1, 1);
      adv("sawup", 14, 0, 1);
      adv("sawup", 18, 0, 1);
      adv("sawup", 20, 0, 1);
      adv("sawup", 10, 1, 1);

      // Triangle 0..9 step 4, loaded with ena high (load must win).
      do_load(2'd2, 4, 0, 9, 1'b1);
      chk("tri9 load out", 32'(out), 0);
      chk("tri9 load dir", 32'(dir_up), 1);
      adv("tri9", 4, 0, 1);
      adv("tri9", 8, 0, 1);
      adv("tri9", 9, 0, 0);
      adv("tri9", 5, 0, 0);
      adv("tri9", 1, 0, 0);
      adv("tri9", 0, 1, 1);
      adv("tri9", 4, 0, 1);

      // Square 0..8 step 2: out follows next direction.
      do_load(2'd3, 2, 0, 8, 1'b1);
      chk("sq load out", 32'(out), 0);
      adv("sq", 8, 0, 1);
      adv("sq", 8, 0, 1);
      adv("sq", 8, 0, 1);
      adv("sq", 0, 0, 0);
      adv("sq", 0, 0, 0);
      adv("sq", 0, 0, 0);
      adv("sq", 0, 0, 0);
      adv("sq", 8, 1, 1);
      adv("sq", 8, 0, 1);
      adv("sq", 8, 0, 1);
      adv("sq", 8, 0, 1);
      adv("sq", 0, 0, 0);

      // Saw-down 5..12 step 3.
      do_load(2'd1, 3, 5, 12, 1'b1);
      chk("sawdn load out", 32'(out), 12);
      chk("sawdn load dir", 32'(dir_up), 0);
      adv("sawdn", 9, 0, 0);
      adv("sawdn", 6, 0, 0);
      adv("sawdn", 5, 0, 0);
      adv("sawdn", 12, 1, 0);
      adv("sawdn", 9, 0, 0);

      // Step of zero behaves as one.
      do_load(2'd0, 0, 0, 3, 1'b1);
      chk("step0 load out", 32'(out), 0);
      adv("step0", 1, 0, 1);
      adv("step0", 2, 0, 1);
      adv("step0", 3, 0, 1);
      adv("step0", 0, 1, 1);

      // Carry past 2^N must clamp, not wrap modulo.
      do_load(2'd0, 200, 100, 255, 1'b1);
      chk("ovf load out", 32'(out), 100);
      adv("ovf", 255, 0, 1);
      adv("ovf", 100, 1, 1);
      adv("ovf", 255, 0, 1);

      // Degenerate config lo == hi.
      do_load(2'd2, 1, 50, 50, 1'b1);
      chk("bad cfg_err", 32'(cfg_err), 1);
      chk("bad out", 32'(out), 50);
      adv("bad hold", 50, 0, 1);
      adv("bad hold", 50, 0, 1);
      chk("bad cfg_err held", 32'(cfg_err), 1);
      do_load(2'd0, 10, 0, 100, 1'b1);
      chk("fix cfg_err", 32'(cfg_err), 0);
      chk("fix out", 32'(out), 0);
      adv("fix", 10, 0, 1);

      // Hold with ena low, then load beating ena, then rst beating load.
      ena = 1'b0;
      tick(); chk("hold out", 32'(out), 10); chk("hold wrap", 32'(wrap), 0);
      tick(); chk("hold out", 32'(out), 10);
      ena = 1'b1;
      adv("resume", 20, 0, 1);
      do_load(2'd0, 5, 30, 60, 1'b1);
      chk("loadwin out", 32'(out), 30);
      adv("loadwin next", 35, 0, 1);
      rst = 1'b1; load = 1'b1; mode = 2'd1; lo = 8'd7; hi = 8'd9; step = 8'd1;
      tick();
      chk("rstwin out", 32'(out), 0);
      chk("rstwin dir_up", 32'(dir_up), 1);
      chk("rstwin wrap", 32'(wrap), 0);
      chk("rstwin cfg_err", 32'(cfg_err), 0);
      rst = 1'b0; load = 1'b0; ena = 1'b1;
      adv("post_rst", 1, 0, 1);
      adv("post_rst", 2, 0, 1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
